fp_sqrt_seq: RTL

Parametrised sequential IEEE-754 square-root unit for the FPU datapath. It computes a correctly rounded root with a restoring digit-recurrence, one result bit per cycle, so convergence does not depend on an initial guess or a stability threshold. Operands use a start/busy/done handshake on a single clock. The unit replaces the free-running Newton iterator and serves any binary format chosen by `EXP_W`/`MAN_W`.

---
 rtl/fp_sqrt_seq_if.sv | 28 ++
 rtl/fp_sqrt_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_seq_if.sv
// fp_sqrt_seq_if -- operand/result handshake bundle for fp_sqrt_seq.
//   W             : word width (1 + EXP_W + MAN_W)
//   start, A      : request and operand, driven by the requester (master)
//   busy, done    : operation in flight / one-cycle completion pulse (slave)
//   Out           : rounded root, held until the next done
//   flag_invalid,
//   flag_inexact  : exception flags, valid with done and held
interface fp_sqrt_seq_if #(
    parameter int W = 32
) ();
    logic         start;
    logic [W-1:0] A;
    logic         busy;
    logic         done;
    logic [W-1:0] Out;
    logic         flag_invalid;
    logic         flag_inexact;

    modport master (
        output start, A,
        input  busy, done, Out, flag_invalid, flag_inexact
    );

    modport slave (
        input  start, A,
        output busy, done, Out, flag_invalid, flag_inexact
    );
endinterface

// File: rtl/fp_sqrt_seq.sv
// fp_sqrt_seq -- sequential IEEE-754 square root, restoring digit recurrence,
// one root bit per cycle, correctly rounded (RNE) or truncated.
//   cpu_clk : sole clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : fp_sqrt_seq_if.slave (start/A in; busy/done/Out/flags out)
// Flow: IDLE -> UNPACK -> (special: IDLE with done) | ITER x (MAN_W+2) -> ROUND -> IDLE.
module fp_sqrt_seq #(
    parameter int EXP_W         = 8,
    parameter int MAN_W         = 23,
    parameter bit ROUND_NEAREST = 1'b1
) (
    input  logic         cpu_clk,
    input  logic         rst_n,
    fp_sqrt_seq_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int QW = MAN_W + 2;           // root bits + guard
    localparam int RW = MAN_W + 4;           // partial remainder
    localparam int NW = 2 * MAN_W + 4;       // radicand, consumed 2 bits per step
    localparam int FW = MAN_W + 1;           // fraction plus carry-out
    localparam int CW = $clog2(MAN_W + 2);

    localparam logic [EXP_W:0] BIAS = {2'b00, {(EXP_W-1){1'b1}}};
    localparam logic [W-1:0]   QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0]   PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_ITER, S_ROUND} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        a_q, a_d;
    logic [NW-1:0]       rad_q, rad_d;
    logic [QW-1:0]       root_q, root_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [W-1:0]        out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                inv_q, inv_d;
    logic                inx_q, inx_d;

    // ---------------- operand decode ----------------
    logic                sgn;
    logic [EXP_W-1:0]    ef;
    logic [MAN_W-1:0]    ff;
    logic                exp_zero, exp_ones, frac_zero, is_special;
    logic signed [EXP_W:0] e_unb, e_half;
    logic [MAN_W+1:0]    sig_m;

    assign sgn        = a_q[W-1];
    assign ef         = a_q[W-2:MAN_W];
    assign ff         = a_q[MAN_W-1:0];
    assign exp_zero   = (ef == '0);
    assign exp_ones   = &ef;
    assign frac_zero  = (ff == '0);
    // Any negative operand is special: zeros keep their sign, the rest go to qNaN.
    assign is_special = sgn | exp_zero | exp_ones;

    assign e_unb  = $signed({1'b0, ef} - BIAS);
    assign e_half = e_unb >>> 1;             // floor(E/2) covers the odd case too
    // Odd E: fold one factor of 2 into the significand so the radicand is in [1,4).
    assign sig_m  = e_unb[0] ? {1'b1, ff, 1'b0} : {1'b0, 1'b1, ff};

    logic [W-1:0] spec_out;
    logic         spec_inv, spec_inx;

    always_comb begin
        spec_out = {sgn, {(W-1){1'b0}}};
        spec_inv = 1'b0;
        spec_inx = 1'b0;
        if (exp_ones && !frac_zero) begin
            spec_out = QNAN;
            spec_inv = ~ff[MAN_W-1];         // only signalling NaNs raise invalid
        end else if (exp_zero) begin
            spec_inx = ~frac_zero;           // subnormal flushed to signed zero
        end else if (sgn) begin
            spec_out = QNAN;
            spec_inv = 1'b1;
        end else begin
            spec_out = PINF;
        end
    end

    // ---------------- one recurrence step ----------------
    logic [RW-1:0] rem_sh, trial, rem_nx;
    logic [QW-1:0] root_nx;
    logic          ge;

    // Remainder stays below 2^(MAN_W+2) before the shift, so the dropped bits are zero.
    assign rem_sh  = {rem_q[RW-3:0], rad_q[NW-1 -: 2]};
    assign trial   = {root_q, 2'b01};
    assign ge      = (rem_sh >= trial);
    assign rem_nx  = ge ? (rem_sh - trial) : rem_sh;
    assign root_nx = {root_q[QW-2:0], ge};

    // ---------------- rounding ----------------
    logic          guard, sticky, inc;
    logic [FW-1:0] frac_rnd;
    logic [W-1:0]  rnd_out;

    assign guard    = root_q[0];
    assign sticky   = (rem_q != '0);
    assign inc      = ROUND_NEAREST && guard && (sticky || root_q[1]);
    // Hidden bit is always 1, so a carry out of the fraction means 10.0...0.
    assign frac_rnd = {1'b0, root_q[MAN_W:1]} + FW'(inc);
    assign rnd_out  = frac_rnd[MAN_W] ? {1'b0, exp_q + EXP_W'(1), {MAN_W{1'b0}}}
                                      : {1'b0, exp_q, frac_rnd[MAN_W-1:0]};

    // ---------------- state register ----------------
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            rad_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            exp_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            inv_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            rad_q   <= rad_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            inv_q   <= inv_d;
            inx_q   <= inx_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_UNPACK;
            S_UNPACK: state_d = is_special ? S_IDLE : S_ITER;
            S_ITER:   if (cnt_q == '0) state_d = S_ROUND;
            S_ROUND:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath / outputs ----------------
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        rad_d  = rad_q;
        root_d = root_q;
        rem_d  = rem_q;
        exp_d  = exp_q;
        out_d  = out_q;
        busy_d = busy_q;
        done_d = 1'b0;
        inv_d  = inv_q;
        inx_d  = inx_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d    = bus.A;
                    busy_d = 1'b1;
                end
            end
            S_UNPACK: begin
                if (is_special) begin
                    out_d  = spec_out;
                    inv_d  = spec_inv;
                    inx_d  = spec_inx;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    rad_d  = {sig_m, {(MAN_W+2){1'b0}}};
                    root_d = '0;
                    rem_d  = '0;
                    cnt_d  = CW'(MAN_W + 1);
                    exp_d  = EXP_W'(e_half + BIAS);
                end
            end
            S_ITER: begin
                rad_d  = {rad_q[NW-3:0], 2'b00};
                root_d = root_nx;
                rem_d  = rem_nx;
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            S_ROUND: begin
                out_d  = rnd_out;
                inv_d  = 1'b0;
                inx_d  = guard | sticky;
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.Out          = out_q;
    assign bus.flag_invalid = inv_q;
    assign bus.flag_inexact = inx_q;
endmodule
